// File: rtl/regfile_wb_sink.sv
// Purpose: integer register file fed by the writeback stage, with two registered read ports for decode; x0 reads as zero.
// Latency: write commits at the sampling edge; reads return 1 cycle after the request, with a one-cycle rf_o_valid pulse.
// Backpressure: none. Requests arriving while rf_o_busy is high (post-reset clear) are dropped; optional macro RF_BYPASS_EN forwards same-cycle writes to reads.
module regfile_wb_sink #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic              rf_clk,
  input  logic              rf_rst,
  input  logic              rf_i_ce,
  input  logic              rf_i_we,
  input  logic [AWIDTH-1:0] rf_i_rd_addr,
  input  logic [DWIDTH-1:0] rf_i_rd_data,
  input  logic              rf_i_rs_re,
  input  logic [AWIDTH-1:0] rf_i_rs1_addr,
  input  logic [AWIDTH-1:0] rf_i_rs2_addr,
  output logic [DWIDTH-1:0] rf_o_rs1_data,
  output logic [DWIDTH-1:0] rf_o_rs2_data,
  output logic              rf_o_valid,
  output logic              rf_o_busy
);

  localparam int NREGS = 2 ** AWIDTH;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [AWIDTH-1:0] r_cnt;
  logic [DWIDTH-1:0] r_regs [0:NREGS-1];
  logic [DWIDTH-1:0] r_rs1_data;
  logic [DWIDTH-1:0] r_rs2_data;
  logic              r_valid;

  logic              w_busy;
  logic              w_wr_user;
  logic              w_wr_en;
  logic [AWIDTH-1:0] w_wr_addr;
  logic [DWIDTH-1:0] w_wr_data;
  logic              w_rd_en;
  logic [DWIDTH-1:0] w_rs1_val;
  logic [DWIDTH-1:0] w_rs2_val;

  // A writeback write qualifies only with both enables and a nonzero target; x0 is never stored.
  assign w_wr_user = rf_i_ce && rf_i_we && (rf_i_rd_addr != '0);

  // State register: reset always restarts the clear sequence.
  always_ff @(posedge rf_clk or negedge rf_rst) begin
    if (!rf_rst) r_state <= S_CLEAR;
    else         r_state <= w_next_state;
  end

  // Next state and the shared write port: the clear sequence owns the port until it finishes.
  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_addr    = rf_i_rd_addr;
    w_wr_data    = rf_i_rd_data;
    w_rd_en      = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_busy    = 1'b1;
        w_wr_en   = 1'b1;
        w_wr_addr = r_cnt;
        w_wr_data = '0;
        if (r_cnt == '1) w_next_state = S_IDLE;
      end
      S_IDLE: begin
        w_wr_en = w_wr_user;
        w_rd_en = rf_i_rs_re;
      end
      default: w_next_state = S_CLEAR;
    endcase
  end

  // Clear counter: starts at x1 (x0 is implicit) and walks the whole file once.
  always_ff @(posedge rf_clk or negedge rf_rst) begin
    if (!rf_rst)                r_cnt <= AWIDTH'(1);
    else if (r_state == S_CLEAR) r_cnt <= r_cnt + AWIDTH'(1);
  end

  // Storage array: deliberately unreset, the clear sequence initialises it.
  always_ff @(posedge rf_clk) begin
    if (w_wr_en) r_regs[w_wr_addr] <= w_wr_data;
  end

  // Read-data selection per port: x0 is zero, optional forwarding of a same-cycle write.
  always_comb begin
    w_rs1_val = '0;
    w_rs2_val = '0;
    if (rf_i_rs1_addr != '0) begin
      w_rs1_val = r_regs[rf_i_rs1_addr];
`ifdef RF_BYPASS_EN
      if (w_wr_user && (rf_i_rd_addr == rf_i_rs1_addr)) w_rs1_val = rf_i_rd_data;
`endif
    end
    if (rf_i_rs2_addr != '0) begin
      w_rs2_val = r_regs[rf_i_rs2_addr];
`ifdef RF_BYPASS_EN
      if (w_wr_user && (rf_i_rd_addr == rf_i_rs2_addr)) w_rs2_val = rf_i_rd_data;
`endif
    end
  end

  // Registered read ports: data holds between requests, valid pulses once per accepted request.
  always_ff @(posedge rf_clk or negedge rf_rst) begin
    if (!rf_rst) begin
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= w_rd_en;
      if (w_rd_en) begin
        r_rs1_data <= w_rs1_val;
        r_rs2_data <= w_rs2_val;
      end
    end
  end

  assign rf_o_rs1_data = r_rs1_data;
  assign rf_o_rs2_data = r_rs2_data;
  assign rf_o_valid    = r_valid;
  assign rf_o_busy     = w_busy;

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Directed bench for regfile_wb_sink: vector table for steady-state accesses,
// hand sequences for the clear timing and the reset cases.
module tb_regfile_wb_sink;

  logic        rf_clk;
  logic        rf_rst;
  logic        rf_i_ce;
  logic        rf_i_we;
  logic [4:0]  rf_i_rd_addr;
  logic [31:0] rf_i_rd_data;
  logic        rf_i_rs_re;
  logic [4:0]  rf_i_rs1_addr;
  logic [4:0]  rf_i_rs2_addr;
  logic [31:0] rf_o_rs1_data;
  logic [31:0] rf_o_rs2_data;
  logic        rf_o_valid;
  logic        rf_o_busy;

  int n_pass = 0;
  int n_total = 0;

  regfile_wb_sink #(.DWIDTH(32), .AWIDTH(5)) dut (
    .rf_clk        (rf_clk),
    .rf_rst        (rf_rst),
    .rf_i_ce       (rf_i_ce),
    .rf_i_we       (rf_i_we),
    .rf_i_rd_addr  (rf_i_rd_addr),
    .rf_i_rd_data  (rf_i_rd_data),
    .rf_i_rs_re    (rf_i_rs_re),
    .rf_i_rs1_addr (rf_i_rs1_addr),
    .rf_i_rs2_addr (rf_i_rs2_addr),
    .rf_o_rs1_data (rf_o_rs1_data),
    .rf_o_rs2_data (rf_o_rs2_data),
    .rf_o_valid    (rf_o_valid),
    .rf_o_busy     (rf_o_busy)
  );

  initial begin
    rf_clk = 1'b0;
    forever #5 rf_clk = ~rf_clk;
  end

  typedef struct {
    logic        ce;
    logic        we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        re;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        exp_valid;
    logic [31:0] exp_rs1;
    logic [31:0] exp_rs2;
  } vec_t;

`ifdef RF_BYPASS_EN
  localparam logic [31:0] HAZ9  = 32'h22;
  localparam logic [31:0] HAZ10 = 32'hBB;
`else
  localparam logic [31:0] HAZ9  = 32'h11;
  localparam logic [31:0] HAZ10 = 32'hAA;
`endif

  function automatic vec_t mk(input logic ce, input logic we, input logic [4:0] rd_addr,
                              input logic [31:0] rd_data, input logic re, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic exp_valid,
                              input logic [31:0] exp_rs1, input logic [31:0] exp_rs2);
    vec_t v;
    v.ce = ce; v.we = we; v.rd_addr = rd_addr; v.rd_data = rd_data;
    v.re = re; v.rs1 = rs1; v.rs2 = rs2;
    v.exp_valid = exp_valid; v.exp_rs1 = exp_rs1; v.exp_rs2 = exp_rs2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    rf_i_ce = v.ce; rf_i_we = v.we; rf_i_rd_addr = v.rd_addr; rf_i_rd_data = v.rd_data;
    rf_i_rs_re = v.re; rf_i_rs1_addr = v.rs1; rf_i_rs2_addr = v.rs2;
  endtask

  // Drive one cycle of inputs, take the edge, check outputs 1 time unit later.
  task automatic apply(input vec_t v, input string name);
    drive(v);
    @(posedge rf_clk);
    #1;
    chk({name, ".valid"}, {31'b0, rf_o_valid}, {31'b0, v.exp_valid});
    chk({name, ".rs1"}, rf_o_rs1_data, v.exp_rs1);
    chk({name, ".rs2"}, rf_o_rs2_data, v.exp_rs2);
  endtask

  // Count edges until busy drops (bounded); flag any valid pulse on the way.
  task automatic count_clear(output int n, output bit vbad);
    n = 0;
    vbad = 1'b0;
    while (n < 100) begin
      @(posedge rf_clk);
      #1;
      n++;
      if (rf_o_valid !== 1'b0) vbad = 1'b1;
      if (rf_o_busy === 1'b0) break;
    end
  endtask

  vec_t idle_v;
  vec_t clr_v;
  vec_t tbl[$];

  initial begin
    int  n;
    bit  vbad;

    idle_v = mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 0, 32'h0, 32'h0);
    // During clear: read every cycle and attempt a write of x3=0x55; both must be dropped.
    clr_v  = mk(1, 1, 5'd3, 32'h55, 1, 5'd3, 5'd3, 0, 32'h0, 32'h0);

    //            ce we rd     data            re rs1    rs2    v  rs1            rs2
    tbl.push_back(mk(1, 1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  5'd0,  0, 32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd5,  5'd0,  1, 32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd1,  5'd1,  0, 32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(1, 1, 5'd0,  32'h12345678, 0, 5'd0,  5'd0,  0, 32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd0,  5'd5,  1, 32'h0,        32'hDEADBEEF));
    tbl.push_back(mk(0, 1, 5'd7,  32'hA5,       0, 5'd0,  5'd0,  0, 32'h0,        32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd7,  5'd7,  1, 32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 5'd7,  32'hA5,       0, 5'd0,  5'd0,  0, 32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd7,  5'd5,  1, 32'h0,        32'hDEADBEEF));
    tbl.push_back(mk(1, 1, 5'd9,  32'h11,       0, 5'd0,  5'd0,  0, 32'h0,        32'hDEADBEEF));
    tbl.push_back(mk(1, 1, 5'd9,  32'h22,       1, 5'd9,  5'd9,  1, HAZ9,         HAZ9));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd9,  5'd9,  1, 32'h22,       32'h22));
    tbl.push_back(mk(1, 1, 5'd10, 32'hAA,       1, 5'd9,  5'd3,  1, 32'h22,       32'h0));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd10, 5'd3,  1, 32'hAA,       32'h0));
    tbl.push_back(mk(1, 1, 5'd10, 32'hBB,       1, 5'd10, 5'd9,  1, HAZ10,        32'h22));
    tbl.push_back(mk(0, 1, 5'd9,  32'h33,       1, 5'd9,  5'd10, 1, 32'h22,       32'hBB));
    tbl.push_back(mk(1, 1, 5'd4,  32'h99,       0, 5'd0,  5'd0,  0, 32'h22,       32'hBB));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd4,  5'd4,  1, 32'h99,       32'h99));

    // Reset state
    rf_rst = 1'b0;
    drive(clr_v);
    #3;
    chk("reset.rs1", rf_o_rs1_data, 32'h0);
    chk("reset.rs2", rf_o_rs2_data, 32'h0);
    chk("reset.valid", {31'b0, rf_o_valid}, 32'h0);
    chk("reset.busy", {31'b0, rf_o_busy}, 32'h1);

    // Clear sequence: exactly 31 busy cycles, no valid pulses
    #9 rf_rst = 1'b1;
    count_clear(n, vbad);
    chk("clear.cycles", n, 32'd31);
    chk("clear.no_valid", {31'b0, vbad}, 32'h0);

    // Every register reads zero after clear (including x3 written during clear)
    for (int i = 1; i < 32; i++)
      apply(mk(0, 0, 5'd0, 32'h0, 1, 5'(i), 5'(32 - i), 1, 32'h0, 32'h0), $sformatf("zero[%0d]", i));
    apply(idle_v, "zero.idle");

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec[%0d]", i));

    // Reset after operation: outputs clear immediately, in-flight read is lost
    drive(mk(0, 0, 5'd0, 32'h0, 1, 5'd4, 5'd4, 0, 32'h0, 32'h0));
    #2 rf_rst = 1'b0;
    #1;
    chk("rst_op.rs1", rf_o_rs1_data, 32'h0);
    chk("rst_op.rs2", rf_o_rs2_data, 32'h0);
    chk("rst_op.busy", {31'b0, rf_o_busy}, 32'h1);
    @(posedge rf_clk);
    #1;
    chk("rst_op.no_valid", {31'b0, rf_o_valid}, 32'h0);
    drive(clr_v);
    #2 rf_rst = 1'b1;

    // Reset mid-clear at cycle 10: clear restarts and runs a full 31 cycles
    repeat (10) @(posedge rf_clk);
    #1;
    chk("midclr.busy_c10", {31'b0, rf_o_busy}, 32'h1);
    rf_rst = 1'b0;
    #1;
    chk("midclr.busy_rst", {31'b0, rf_o_busy}, 32'h1);
    #2 rf_rst = 1'b1;
    count_clear(n, vbad);
    chk("midclr.cycles", n, 32'd31);
    chk("midclr.no_valid", {31'b0, vbad}, 32'h0);

    // x4 was cleared, x3 write during clear dropped again
    apply(mk(0, 0, 5'd0, 32'h0, 1, 5'd4, 5'd3, 1, 32'h0, 32'h0), "after_rst.x4_x3");
    apply(idle_v, "after_rst.idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_wb_sink.md
# regfile_wb_sink

Integer register file that sits directly downstream of the writeback stage and consumes its destination-register write (`rd` address, data, write enable, clock enable). It provides two registered read ports to the decode stage. After reset it runs a self-clearing sequence that zeroes every register before it accepts any access. `x0` is hardwired to zero.

## Interface
**Parameters**
- `DWIDTH`, 32: register data width.
- `AWIDTH`, 5: register address width; the file holds 2^AWIDTH registers.

**Ports**
- `rf_clk`, in, 1: clock; all state changes on the rising edge.
- `rf_rst`, in, 1: reset, active-low, asynchronous.
- `rf_i_ce`, in, 1: writeback clock enable; qualifies the write.
- `rf_i_we`, in, 1: destination write enable from writeback.
- `rf_i_rd_addr`, in, AWIDTH: destination register address.
- `rf_i_rd_data`, in, DWIDTH: destination write data.
- `rf_i_rs_re`, in, 1: read request from decode.
- `rf_i_rs1_addr`, in, AWIDTH: source 1 address.
- `rf_i_rs2_addr`, in, AWIDTH: source 2 address.
- `rf_o_rs1_data`, out, DWIDTH: registered source 1 data.
- `rf_o_rs2_data`, out, DWIDTH: registered source 2 data.
- `rf_o_valid`, out, 1: one-cycle pulse; read data is valid.
- `rf_o_busy`, out, 1: high while the clear sequence runs.

## Operation
- **FSM states:** `CLEAR` and `IDLE`.
  - Reset forces `CLEAR`.
  - The FSM goes `CLEAR` → `IDLE` on the cycle after the clear counter writes address 2^AWIDTH−1.
  - `IDLE` has no exit except reset.
- **CLEAR:**
  - An AWIDTH-bit counter starts at 1 and writes zero to `regs[counter]` each cycle, then increments.
  - `rf_o_busy` = 1.
  - All write and read requests are ignored and dropped. They are not queued.
  - `rf_o_valid` stays 0.
- **Write (IDLE):**
  - The write is performed when `rf_i_ce` && `rf_i_we` && `rf_i_rd_addr` != 0: `regs[rf_i_rd_addr]` <= `rf_i_rd_data`.
  - Writes to address 0 are discarded.
- **Read (IDLE):**
  - When `rf_i_rs_re` = 1, the block registers rs1 and rs2 data and asserts `rf_o_valid` for one cycle.
  - Address 0 always reads 0.
  - When `rf_i_rs_re` = 0, the data outputs hold their last value and `rf_o_valid` = 0.
- **Simultaneous read and write, same nonzero address:** the result depends on `RF_BYPASS_EN` (see Configuration).
- **Simultaneous read and write, different addresses:** the read returns the stored value. The write completes independently.
- **Both read ports at the same address:** both ports return the identical value.
- **Array contents:** the array itself has no reset. Contents are undefined until `CLEAR` completes. `x0` is never stored.

## Timing
- **Reset values:**
  - `rf_o_rs1_data` = 0, `rf_o_rs2_data` = 0
  - `rf_o_valid` = 0
  - `rf_o_busy` = 1
  - counter = 1
  - state = `CLEAR`
- **Clear duration:** 2^AWIDTH−1 cycles after reset release, i.e. 31 cycles for AWIDTH=5. `rf_o_busy` falls on the edge that enters `IDLE`.
- **Write latency:** the write commits at the sampling edge. A read request on the following cycle returns the new value.
- **Read latency:** 1 cycle. The request is sampled at edge N; data and `rf_o_valid` are visible after edge N.
- **Back-to-back reads:** a read every cycle is allowed, giving one valid pulse per request. `rf_o_valid` stays high continuously during back-to-back reads.
- **Reset mid-clear or mid-operation:**
  - Outputs return to their reset values immediately (asynchronously).
  - The clear sequence restarts from counter = 1.
  - An in-flight read is lost; no `rf_o_valid` pulse is produced for it.

## Configuration
- **Macro:** `RF_BYPASS_EN`.
- **Defined:** write-to-read forwarding is enabled. A read in the same cycle as a qualifying write to the same nonzero address returns `rf_i_rd_data`. This applies independently per port.
- **Undefined:** no forwarding. That read returns the pre-write stored value. Decode hazard logic must then stall one cycle.
- All other behaviour is identical in both builds.

## Test plan
- **Clear sequence:** release reset, hold `rf_i_rs_re`=1 → `rf_o_busy`=1 for exactly 31 cycles and `rf_o_valid`=0 throughout. Then read x1..x31 → all 0.
- **Basic write/read:** write x5=0xDEADBEEF, then next cycle read rs1=5, rs2=0 → after 1 cycle: `rf_o_rs1_data`=0xDEADBEEF, `rf_o_rs2_data`=0, `rf_o_valid`=1 for one cycle.
- **x0 and enable gating:**
  - Write x0=0x12345678 → reading x0 returns 0.
  - Write x7=0xA5 with `rf_i_ce`=0 → x7 reads 0.
- **Same-cycle hazard:** x9=0x11, then write x9=0x22 while reading rs1=rs2=9 in the same cycle → both ports return 0x22 with `RF_BYPASS_EN` defined, 0x11 without it. A read the next cycle returns 0x22 in both builds.
- **Requests during clear are dropped:** a write of x3=0x55 issued during `CLEAR` → after clear, x3 reads 0.
- **Reset mid-clear and after operation:**
  - Assert `rf_rst` at clear cycle 10 → busy stays 1, and a full 31 cycles elapse after release.
  - Assert `rf_rst` after x4=0x99 → outputs go to 0 immediately, and after the new clear x4 reads 0.
